// File: rtl/multi_mac.sv
// multi_mac: N-lane signed multiply-accumulate with one shared coefficient.
//
// Each lane computes acc_i += a * b_i (or acc_i = a * b_i when clr is set),
// using a full-precision saturating accumulator. The result is the
// accumulator arithmetically shifted right by SHIFT and clamped to WIDTH bits.
// Three pipeline stages (input register, product, accumulate) all advance
// only when ce=1. A synchronous active-high reset overrides ce.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   ce         clock enable; 0 stalls every register
//   valid_in   a/b/clr carry a sample this cycle
//   clr        with valid_in, start a new accumulation instead of adding
//   a          shared signed coefficient, WIDTH bits
//   b          packed signed samples, lane i at [i*WIDTH +: WIDTH]
//   res        packed signed results, same packing as b
//   valid_out  res/sat belong to a newly accumulated sample
//   sat        per-lane flag: accumulator add or output clamp saturated
module multi_mac #(
    parameter int unsigned WIDTH     = 18,
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned ACC_WIDTH = 48,
    parameter int unsigned SHIFT     = 17
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         valid_in,
    input  logic                         clr,
    input  logic [WIDTH-1:0]             a,
    input  logic [CHANNELS*WIDTH-1:0]    b,
    output logic [CHANNELS*WIDTH-1:0]    res,
    output logic                         valid_out,
    output logic [CHANNELS-1:0]          sat
);

    localparam int unsigned PW = 2 * WIDTH;             // full product width
    localparam int unsigned SW = ACC_WIDTH + 1;         // sum width incl. carry
    localparam int unsigned HW = ACC_WIDTH - WIDTH + 1; // bits that must agree for no clamp

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0]     RES_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]     RES_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Control and coefficient state shared by all lanes
    logic signed [WIDTH-1:0] a_s1;
    logic                    clr_s1;
    logic                    vld_s1;
    logic                    clr_s2;
    logic                    vld_s2;

    // Shared pipeline control; valid_out is the stage-3 valid
    always_ff @(posedge clk) begin
        if (reset) begin
            a_s1      <= '0;
            clr_s1    <= 1'b0;
            vld_s1    <= 1'b0;
            clr_s2    <= 1'b0;
            vld_s2    <= 1'b0;
            valid_out <= 1'b0;
        end else if (ce) begin
            a_s1      <= a;
            clr_s1    <= clr;
            vld_s1    <= valid_in;
            clr_s2    <= clr_s1;
            vld_s2    <= vld_s1;
            valid_out <= vld_s2;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        logic signed [WIDTH-1:0]     b_s1;
        logic signed [PW-1:0]        p_s2;
        logic signed [ACC_WIDTH-1:0] acc;
        logic signed [WIDTH-1:0]     res_q;
        logic                        sat_q;

        logic signed [ACC_WIDTH-1:0] p_ext_c;
        logic signed [SW-1:0]        sum_c;
        logic signed [ACC_WIDTH-1:0] acc_nxt_c;
        logic signed [ACC_WIDTH-1:0] sh_c;
        logic        [HW-1:0]        hi_c;
        logic signed [WIDTH-1:0]     res_nxt_c;
        logic                        ovf_c;
        logic                        clamp_c;

        // Next accumulator value, shifted/clamped result and saturation flag
        always_comb begin
            p_ext_c   = ACC_WIDTH'(p_s2);
            sum_c     = SW'(acc) + SW'(p_ext_c);
            ovf_c     = 1'b0;
            acc_nxt_c = acc;
            if (vld_s2) begin
                if (clr_s2) begin
                    acc_nxt_c = p_ext_c;
                end else if (sum_c[SW-1] != sum_c[SW-2]) begin
                    // Carry-out disagrees with sign: true sign is the carry bit
                    ovf_c     = 1'b1;
                    acc_nxt_c = sum_c[SW-1] ? ACC_MIN : ACC_MAX;
                end else begin
                    acc_nxt_c = sum_c[ACC_WIDTH-1:0];
                end
            end

            sh_c      = acc_nxt_c >>> SHIFT;
            hi_c      = sh_c[ACC_WIDTH-1:WIDTH-1];
            clamp_c   = 1'b0;
            res_nxt_c = sh_c[WIDTH-1:0];
            // Result fits only if all bits above the result sign match it
            if (!((&hi_c) || (~|hi_c))) begin
                clamp_c   = 1'b1;
                res_nxt_c = sh_c[ACC_WIDTH-1] ? RES_MIN : RES_MAX;
            end
        end

        // Lane datapath: input sample, product, accumulator and outputs
        always_ff @(posedge clk) begin
            if (reset) begin
                b_s1  <= '0;
                p_s2  <= '0;
                acc   <= '0;
                res_q <= '0;
                sat_q <= 1'b0;
            end else if (ce) begin
                b_s1 <= b[i*WIDTH +: WIDTH];
                p_s2 <= PW'(a_s1) * PW'(b_s1);
                if (vld_s2) begin
                    acc   <= acc_nxt_c;
                    res_q <= res_nxt_c;
                    sat_q <= ovf_c | clamp_c;
                end
            end
        end

        assign res[i*WIDTH +: WIDTH] = res_q;
        assign sat[i]                = sat_q;
    end

endmodule

// File: tb/tb_multi_mac.sv
// tb_multi_mac: directed and randomized bench for multi_mac.
// Two instances: the default build (2 lanes, 48-bit acc, SHIFT=17) and a
// 4-lane build with a 36-bit accumulator and SHIFT=0. A behavioural model
// computes expected results per accepted sample with plain integer
// arithmetic and schedules them two enabled edges later.
module tb_multi_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ce;
    logic        v0, c0, vo0;
    logic [17:0] a0;
    logic [35:0] b0, r0;
    logic [1:0]  s0;
    logic        v1, c1, vo1;
    logic [17:0] a1;
    logic [71:0] b1, r1;
    logic [3:0]  s1;

    multi_mac #(.WIDTH(18), .CHANNELS(2), .ACC_WIDTH(48), .SHIFT(17)) dut0 (
        .clk(clk), .reset(reset), .ce(ce), .valid_in(v0), .clr(c0),
        .a(a0), .b(b0), .res(r0), .valid_out(vo0), .sat(s0)
    );

    multi_mac #(.WIDTH(18), .CHANNELS(4), .ACC_WIDTH(36), .SHIFT(0)) dut1 (
        .clk(clk), .reset(reset), .ce(ce), .valid_in(v1), .clr(c1),
        .a(a1), .b(b1), .res(r1), .valid_out(vo1), .sat(s1)
    );

    typedef struct {
        int          due;
        logic [71:0] rp;
        logic [3:0]  s;
    } exp_t;

    int nch [2] = '{2, 4};
    int aw  [2] = '{48, 36};
    int shf [2] = '{17, 0};

    exp_t        q0[$];
    exp_t        q1[$];
    longint      macc [2][4];
    int          ecnt [2];
    logic        evo  [2];
    logic [71:0] eres [2];
    logic [3:0]  esat [2];

    int vectors     = 0;
    int miscompares = 0;

    function automatic longint sx(input longint v, input int w);
        longint m;
        longint x;
        m = (64'sd1 <<< w) - 1;
        x = v & m;
        if (x[w-1]) x = x - (64'sd1 <<< w);
        return x;
    endfunction

    function automatic longint lane(input logic [71:0] v, input int i);
        return sx(64'(v >> (18 * i)), 18);
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Model one clock edge for instance d using the inputs present now
    task automatic model_edge(input int d, input logic vin, input logic cl,
                              input logic [17:0] av, input logic [71:0] bv);
        exp_t   e;
        longint p, acc, r, amx, amn;
        amx = (64'sd1 <<< (aw[d] - 1)) - 1;
        amn = -amx - 1;
        if (reset) begin
            for (int i = 0; i < 4; i++) macc[d][i] = 0;
            if (d == 0) q0.delete(); else q1.delete();
            evo[d]  = 1'b0;
            eres[d] = '0;
            esat[d] = '0;
            return;
        end
        if (!ce) return;
        ecnt[d]++;
        if (vin) begin
            e.due = ecnt[d] + 2;
            e.rp  = '0;
            e.s   = '0;
            for (int i = 0; i < nch[d]; i++) begin
                p = sx(64'(av), 18) * lane(bv, i);
                if (cl) begin
                    acc = p;
                end else begin
                    acc = macc[d][i] + p;
                    if (acc > amx) begin acc = amx; e.s[i] = 1'b1; end
                    if (acc < amn) begin acc = amn; e.s[i] = 1'b1; end
                end
                macc[d][i] = acc;
                r = acc >>> shf[d];
                if (r > 131071)  begin r = 131071;  e.s[i] = 1'b1; end
                if (r < -131072) begin r = -131072; e.s[i] = 1'b1; end
                e.rp[18*i +: 18] = 18'(r);
            end
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (d == 0 && q0.size() > 0 && q0[0].due == ecnt[0]) begin
            e = q0.pop_front();
            evo[0] = 1'b1; eres[0] = e.rp; esat[0] = e.s;
        end else if (d == 1 && q1.size() > 0 && q1[0].due == ecnt[1]) begin
            e = q1.pop_front();
            evo[1] = 1'b1; eres[1] = e.rp; esat[1] = e.s;
        end else begin
            evo[d] = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("d0_valid", 64'(vo0), 64'(evo[0]));
        check("d0_sat", 64'(s0), 64'(esat[0]));
        for (int i = 0; i < 2; i++)
            check($sformatf("d0_res%0d", i), lane(72'(r0), i), lane(eres[0], i));
        check("d1_valid", 64'(vo1), 64'(evo[1]));
        check("d1_sat", 64'(s1), 64'(esat[1]));
        for (int i = 0; i < 4; i++)
            check($sformatf("d1_res%0d", i), lane(r1, i), lane(eres[1], i));
    endtask

    task automatic step();
        model_edge(0, v0, c0, a0, 72'(b0));
        model_edge(1, v1, c1, a1, b1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic logic [17:0] rnd18();
        int unsigned k;
        k = $urandom_range(0, 7);
        case (k)
            0:       return 18'h20000;
            1:       return 18'h1FFFF;
            2, 3:    return 18'($urandom_range(0, 127)) - 18'd64;
            default: return 18'($urandom);
        endcase
    endfunction

    initial begin
        ecnt[0] = 0; ecnt[1] = 0;
        reset = 1'b1; ce = 1'b1;
        v0 = 1'b0; c0 = 1'b0; a0 = '0; b0 = '0;
        v1 = 1'b0; c1 = 1'b0; a1 = '0; b1 = '0;

        // Reset held two cycles: everything reads zero
        step(); step();
        check("rst_res0", 64'(r0), 0);
        check("rst_valid", 64'(vo0), 0);
        reset = 1'b0;

        // Single sample, latency of three enabled edges
        v0 = 1'b1; c0 = 1'b1; a0 = 18'd65536;
        b0 = {18'(-65536), 18'(65536)};
        step();
        v0 = 1'b0; c0 = 1'b0;
        step();
        check("lat_early_valid", 64'(vo0), 0);
        step();
        check("lat_valid", 64'(vo0), 1);
        check("lat_res0", lane(72'(r0), 0), 32768);
        check("lat_res1", lane(72'(r0), 1), -32768);
        check("lat_sat", 64'(s0), 0);

        // Four back-to-back accumulations, last one clamps the output
        a0 = 18'd65536; b0 = {18'd0, 18'd65536};
        v0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            c0 = (k == 0);
            step();
        end
        v0 = 1'b0; c0 = 1'b0;
        step(); step();
        check("acc4_res0", lane(72'(r0), 0), 131071);
        check("acc4_sat0", 64'(s0[0]), 1);

        // Same with a three-cycle stall after the second sample
        v0 = 1'b1; c0 = 1'b1;
        step();
        c0 = 1'b0;
        step();
        ce = 1'b0; a0 = rnd18(); c0 = 1'b1;
        for (int k = 0; k < 3; k++) step();
        ce = 1'b1; a0 = 18'd65536; c0 = 1'b0;
        step(); step();
        v0 = 1'b0;
        step(); step();
        check("stall_res0", lane(72'(r0), 0), 131071);
        check("stall_sat0", 64'(s0[0]), 1);

        // Accumulator saturation in the 36-bit, SHIFT=0 build
        v1 = 1'b1; c1 = 1'b1; a1 = 18'(-131072); b1 = 72'(18'(-131072));
        step();
        c1 = 1'b0;
        step();
        v1 = 1'b0;
        step(); step();
        check("accsat_res0", lane(r1, 0), 131071);
        check("accsat_sat0", 64'(s1[0]), 1);
        v1 = 1'b1; c1 = 1'b1; a1 = 18'd1; b1 = 72'd5;
        step();
        v1 = 1'b0; c1 = 1'b0;
        step(); step();
        check("clr_res0", lane(r1, 0), 5);
        check("clr_sat0", 64'(s1[0]), 0);

        // Reset while two samples are in flight
        v0 = 1'b1; c0 = 1'b1; a0 = rnd18(); b0 = {rnd18(), rnd18()};
        v1 = 1'b1; c1 = 1'b1; a1 = 18'd7; b1 = {18'd9, 18'd8, 18'd7, 18'd6};
        step(); step();
        reset = 1'b1; v0 = 1'b0; v1 = 1'b0;
        step();
        reset = 1'b0;
        step(); step(); step();
        check("midrst_valid", 64'(vo1), 0);
        check("midrst_res0", lane(r1, 0), 0);
        v1 = 1'b1; c1 = 1'b0; a1 = 18'd2; b1 = 72'd3;
        step();
        v1 = 1'b0;
        step(); step();
        check("midrst_next_res0", lane(r1, 0), 6);

        // Four-lane sweep, then bubbles must leave results untouched
        v1 = 1'b1; c1 = 1'b1; a1 = 18'd1; b1 = {18'd4, 18'd3, 18'd2, 18'd1};
        step();
        v1 = 1'b0; c1 = 1'b0;
        step(); step();
        for (int i = 0; i < 4; i++) check($sformatf("sweep_res%0d", i), lane(r1, i), i + 1);
        step(); step(); step();
        for (int i = 0; i < 4; i++) check($sformatf("bubble_res%0d", i), lane(r1, i), i + 1);

        // Randomized traffic on both instances
        for (int n = 0; n < 500; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            ce    = ($urandom_range(0, 9) != 0);
            v0    = ($urandom_range(0, 9) < 7);
            c0    = ($urandom_range(0, 4) == 0);
            a0    = rnd18();
            b0    = {rnd18(), rnd18()};
            v1    = ($urandom_range(0, 9) < 7);
            c1    = ($urandom_range(0, 4) == 0);
            a1    = rnd18();
            b1    = {rnd18(), rnd18(), rnd18(), rnd18()};
            step();
        end
        reset = 1'b0; ce = 1'b1; v0 = 1'b0; v1 = 1'b0;
        for (int n = 0; n < 3; n++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
